// File: rtl/serial_2s_complement.sv
// Bit-serial two's-complement negator: walks the accepted word LSB-first,
// copying bits up to and including the first 1 and inverting every bit after it.
module serial_2s_complement #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        INVERT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             bit_in;
    logic             last_bit;

    assign bit_in   = shift_q[0];
    assign last_bit = (cnt_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // The WIDTH-th processed bit ends the word on either path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = COPY;
                end
            end
            COPY: begin
                if (last_bit) begin
                    state_d = DONE;
                end else if (bit_in) begin
                    state_d = INVERT;
                end
            end
            INVERT: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result fills from the MSB end so the word lands in place after WIDTH shifts.
    always_comb begin
        shift_d  = shift_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    ovf_d   = (in_data == MIN_NEG);
                end
            end
            COPY: begin
                result_d = {bit_in, result_q[WIDTH-1:1]};
                shift_d  = shift_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end
            INVERT: begin
                result_d = {~bit_in, result_q[WIDTH-1:1]};
                shift_d  = shift_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_data  = result_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_serial_2s_complement.sv
// Self-checking bench for serial_2s_complement: directed cases, reset mid-word,
// backpressure, exhaustive back-to-back run and randomized words with stalls.
module tb_serial_2s_complement;

    localparam int WIDTH = 4;
    localparam int MOD   = 2 ** WIDTH;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    int compared;
    int mismatched;

    serial_2s_complement #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] refNeg(input int x);
        return WIDTH'((MOD - x) % MOD);
    endfunction

    function automatic logic refOvf(input int x);
        return (x == MOD / 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One full word: accept, wait for result, optional stall, then handshake.
    task automatic applyStimulus(input int x, input int stall);
        int waitCnt;
        int lat;
        int lowCnt;
        logic [WIDTH-1:0] expData;
        logic             expOvf;
        expData = refNeg(x);
        expOvf  = refOvf(x);
        waitCnt = 0;
        while (!in_ready && waitCnt < 50) begin
            step();
            waitCnt++;
        end
        checkOutput("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = WIDTH'(x);
        out_ready = (stall == 0);
        step();
        in_valid = 1'b0;
        lat      = 0;
        lowCnt   = 0;
        while (!out_valid && lat < 50) begin
            if (!in_ready) lowCnt++;
            step();
            lat++;
        end
        if (!in_ready) lowCnt++;
        checkOutput("latency", 32'(lat), 32'(WIDTH));
        checkOutput("out_data", 32'(out_data), 32'(expData));
        checkOutput("out_ovf", 32'(out_ovf), 32'(expOvf));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(x) ^ {WIDTH{1'b1}};
            step();
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_data", 32'(out_data), 32'(expData));
            checkOutput("stall_ovf", 32'(out_ovf), 32'(expOvf));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("post_ready", 32'(in_ready), 32'd1);
        checkOutput("post_valid", 32'(out_valid), 32'd0);
        if (stall == 0) begin
            checkOutput("ready_low_cycles", 32'(lowCnt), 32'(WIDTH + 1));
        end
    endtask

    task automatic resetMidWord(input int x);
        in_valid  = 1'b1;
        in_data   = WIDTH'(x);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_ovf", 32'(out_ovf), 32'd0);
    endtask

    initial begin
        int acceptQ[$];
        int nextVal;
        int outCnt;
        int lastOut;
        int cyc;
        int x;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        step();
        step();
        rst = 1'b0;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_out_ovf", 32'(out_ovf), 32'd0);

        $display("[TB] directed words");
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(6, 0);
        applyStimulus(11, 0);
        applyStimulus(8, 0);

        $display("[TB] reset mid-word");
        resetMidWord(8);
        resetMidWord(5);
        applyStimulus(5, 0);

        $display("[TB] backpressure");
        applyStimulus(3, 6);

        $display("[TB] exhaustive back-to-back");
        nextVal   = 0;
        outCnt    = 0;
        lastOut   = 0;
        in_valid  = 1'b1;
        in_data   = '0;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 200 && outCnt < MOD; cyc++) begin
            if (in_ready && in_valid) begin
                acceptQ.push_back(nextVal);
                nextVal++;
                step();
                in_data = WIDTH'(nextVal);
                if (nextVal >= MOD) in_valid = 1'b0;
            end else begin
                step();
            end
            if (out_valid) begin
                x = (acceptQ.size() > 0) ? acceptQ.pop_front() : -1;
                checkOutput("b2b_data", 32'(out_data), 32'(refNeg(x)));
                checkOutput("b2b_ovf", 32'(out_ovf), 32'(refOvf(x)));
                if (outCnt > 0) begin
                    checkOutput("b2b_spacing", 32'(cyc - lastOut), 32'(WIDTH + 2));
                end
                lastOut = cyc;
                outCnt++;
            end
        end
        in_valid = 1'b0;
        step();
        step();
        checkOutput("b2b_count", 32'(outCnt), 32'(MOD));
        checkOutput("b2b_idle", 32'(in_ready), 32'd1);

        $display("[TB] random words");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
